// File: rtl/lisa_uart_pkg.sv
// Shared definitions for the Lisa 8N1 UART peripherals (TX and RX).
//  state_t        : frame sequencer states
//  TICKS_PER_BIT  : baud_ref rising edges per bit time (16x oversample)
//  DATA_BITS      : payload bits per frame
package lisa_uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   localparam int TICKS_PER_BIT = 16;
   localparam int DATA_BITS     = 8;
   localparam int TCNT_W        = $clog2(TICKS_PER_BIT);
   localparam int BITN_W        = $clog2(DATA_BITS);

endpackage

// File: rtl/lisa_tx_fifo.sv
// Small synchronous FIFO holding bytes waiting to be transmitted.
// Pointers carry one extra wrap bit, so full and empty are told apart
// without a separate counter.
//  clk, rst_n : clock, async active-low reset (empties the FIFO)
//  push, din  : write request and data (taken if not full, or if popping)
//  pop, dout  : read request and head-of-queue data (dout valid when !empty)
//  full       : DEPTH entries held
//  empty      : no entries held
//  count      : number of entries held
module lisa_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wptr;
   logic [AW:0]  rptr;
   logic         do_push;
   logic         do_pop;

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign count = wptr - rptr;
   assign dout  = mem[rptr[AW-1:0]];

   // When full, a simultaneous pop frees the slot being written: the head
   // is read out this cycle before the new byte lands in it on the edge.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + PTR_ONE;
         if (do_pop)  rptr <= rptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/lisa_tx8n.sv
// Lisa 8N1 UART transmitter: host bytes are queued in a small FIFO and
// sent LSB first as start / 8 data / stop, each bit 16 baud_ref ticks long.
//  clk       : system clock
//  rst_n     : async active-low reset; aborts any frame, drops queued bytes
//  baud_ref  : 16x baud reference shared with the RX side
//  d, wr     : byte to send and write strobe (rising edge writes once)
//  txd       : serial output, idles high, driven straight from a flop
//  tx_ready  : FIFO has room for another byte
//  tx_busy   : frame in flight or bytes still queued
module lisa_tx8n
   import lisa_uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 baud_ref,
   input  logic [DATA_BITS-1:0] d,
   input  logic                 wr,
   output logic                 txd,
   output logic                 tx_ready,
   output logic                 tx_busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]       DEPTH_C  = (AW+1)'(FIFO_DEPTH);
   localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TICKS_PER_BIT-1);
   localparam logic [TCNT_W-1:0] TCNT_ONE = TCNT_W'(1);
   localparam logic [BITN_W-1:0] BITN_MAX = BITN_W'(DATA_BITS-1);
   localparam logic [BITN_W-1:0] BITN_ONE = BITN_W'(1);

   state_t               state;
   state_t               state_nxt;
   logic                 wr_q;
   logic                 baud_q;
   logic                 wr_rise;
   logic                 tick;
   logic                 last_tick;
   logic [TCNT_W-1:0]    tcnt;
   logic [BITN_W-1:0]    bitn;
   logic [DATA_BITS-1:0] shreg;
   logic                 txd_nxt;
   logic                 pop;
   logic                 shift;
   logic                 push;
   logic [DATA_BITS-1:0] fifo_dout;
   logic                 full;
   logic                 empty;
   logic [AW:0]          count;

   // ---------------- edge detects ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q   <= 1'b0;
         baud_q <= 1'b0;
      end else begin
         wr_q   <= wr;
         baud_q <= baud_ref;
      end
   end

   assign wr_rise   = wr & ~wr_q;
   assign tick      = baud_ref & ~baud_q;
   assign last_tick = tick && (tcnt == TCNT_MAX);

   // A write into a full FIFO still lands if STOP pops the head that cycle.
   assign push = wr_rise & (~full | pop);

   lisa_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (DATA_BITS)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (d),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign tx_ready = (count < DEPTH_C);
   assign tx_busy  = (state != IDLE) | ~empty;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      if (tick) begin
         case (state)
            IDLE:  if (!empty)                      state_nxt = START;
            START: if (last_tick)                   state_nxt = DATA;
            DATA:  if (last_tick && bitn == BITN_MAX) state_nxt = STOP;
            STOP:  if (last_tick)                   state_nxt = empty ? IDLE : START;
            default:                                state_nxt = IDLE;
         endcase
      end
   end

   // ---------------- FSM: outputs / datapath controls ----------------
   // Only the registered FIFO state is consulted, so a byte pushed on a
   // tick cycle waits for the following tick.
   always_comb begin
      pop     = 1'b0;
      shift   = 1'b0;
      txd_nxt = txd;
      if (tick) begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  pop     = 1'b1;
                  txd_nxt = 1'b0;
               end
            end
            START: begin
               if (last_tick) txd_nxt = shreg[0];
            end
            DATA: begin
               if (last_tick) begin
                  if (bitn == BITN_MAX) begin
                     txd_nxt = 1'b1;
                  end else begin
                     shift   = 1'b1;
                     txd_nxt = shreg[1];
                  end
               end
            end
            STOP: begin
               // Chain straight into the next start bit: no idle gap.
               if (last_tick && !empty) begin
                  pop     = 1'b1;
                  txd_nxt = 1'b0;
               end
            end
            default: txd_nxt = 1'b1;
         endcase
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         txd   <= 1'b1;
         tcnt  <= '0;
         bitn  <= '0;
         shreg <= '0;
      end else begin
         txd <= txd_nxt;
         if (pop)        shreg <= fifo_dout;
         else if (shift) shreg <= {1'b0, shreg[DATA_BITS-1:1]};
         // tcnt sits at 0 while idle; in a frame it free-runs and its
         // natural wrap lines up with every bit boundary.
         if (tick) tcnt <= (state == IDLE) ? '0 : tcnt + TCNT_ONE;
         if (last_tick) bitn <= (state == DATA) ? bitn + BITN_ONE : '0;
      end
   end

endmodule
